// File: rtl/exec_stage_if.sv
// Decode-to-memory bus of the execute stage: decode inputs, forwarding inputs,
// hazard-unit controls and the M-stage outputs.
interface exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             stall;
  logic             flush;
  logic             valid_d;
  logic [3:0]       alu_ctrl_d;
  logic [3:0]       cond_d;
  logic             reg_write_d;
  logic             mem_write_d;
  logic             mem_to_reg_d;
  logic             pc_src_d;
  logic             alu_src_d;
  logic [1:0]       flag_write_d;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;
  logic [WIDTH-1:0] ext_d;
  logic [AW-1:0]    wa_d;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [WIDTH-1:0] alu_fwd_m;
  logic [WIDTH-1:0] result_w;

  logic             busy;
  logic             valid_m;
  logic             reg_write_m;
  logic             mem_write_m;
  logic             mem_to_reg_m;
  logic             pc_src_m;
  logic [WIDTH-1:0] alu_result_m;
  logic [WIDTH-1:0] write_data_m;
  logic [AW-1:0]    wa_m;
  logic [3:0]       flags;

  modport master (
    output stall, flush, valid_d, alu_ctrl_d, cond_d, reg_write_d, mem_write_d,
           mem_to_reg_d, pc_src_d, alu_src_d, flag_write_d, rd1_d, rd2_d, ext_d,
           wa_d, fwd_a, fwd_b, alu_fwd_m, result_w,
    input  busy, valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m,
           alu_result_m, write_data_m, wa_m, flags
  );

  modport slave (
    input  stall, flush, valid_d, alu_ctrl_d, cond_d, reg_write_d, mem_write_d,
           mem_to_reg_d, pc_src_d, alu_src_d, flag_write_d, rd1_d, rd2_d, ext_d,
           wa_d, fwd_a, fwd_b, alu_fwd_m, result_w,
    output busy, valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m,
           alu_result_m, write_data_m, wa_m, flags
  );
endinterface

// File: rtl/exec_stage_mc.sv
// ARM execute stage: E register, forwarding muxes, conditional execution with
// local NZCV, single-cycle ALU and a shift-add multiplier that stalls upstream.
module exec_stage_mc #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input logic         clk,
  input logic         reset,
  exec_stage_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  typedef struct packed {
    logic             valid;
    logic [3:0]       alu_ctrl;
    logic [3:0]       cond;
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             pc_src;
    logic             alu_src;
    logic [1:0]       flag_write;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] ext;
    logic [AW-1:0]    wa;
  } e_reg_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             pc_src;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    wa;
  } m_reg_t;

  e_reg_t           e_q, e_d;
  m_reg_t           m_q, m_d;
  logic [3:0]       flags_q, flags_d;
  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] a_op, b_reg, b_op, alu_res;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             alu_c, alu_v, nz_ok, cv_ok;
  logic             cp, mul_start, busy, move, gate;
  logic             fn, fz, fc, fv;

  always_comb begin
    case (bus.fwd_a)
      2'b01:   a_op = bus.result_w;
      2'b10:   a_op = bus.alu_fwd_m;
      default: a_op = e_q.rd1;
    endcase
    case (bus.fwd_b)
      2'b01:   b_reg = bus.result_w;
      2'b10:   b_reg = bus.alu_fwd_m;
      default: b_reg = e_q.rd2;
    endcase
    b_op = e_q.alu_src ? e_q.ext : b_reg;
  end

  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    case (e_q.cond)
      4'h0:    cp = fz;
      4'h1:    cp = !fz;
      4'h2:    cp = fc;
      4'h3:    cp = !fc;
      4'h4:    cp = fn;
      4'h5:    cp = !fn;
      4'h6:    cp = fv;
      4'h7:    cp = !fv;
      4'h8:    cp = fc && !fz;
      4'h9:    cp = !fc || fz;
      4'hA:    cp = (fn == fv);
      4'hB:    cp = (fn != fv);
      4'hC:    cp = !fz && (fn == fv);
      4'hD:    cp = fz || (fn != fv);
      4'hE:    cp = 1'b1;
      default: cp = 1'b0;
    endcase
  end

  assign sum_ext  = {1'b0, a_op} + {1'b0, b_op};
  assign diff_ext = {1'b0, a_op} + {1'b0, ~b_op} + (WIDTH+1)'(1);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    nz_ok   = 1'b1;
    cv_ok   = 1'b0;
    case (e_q.alu_ctrl)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum_ext[WIDTH-1] != a_op[WIDTH-1]);
        cv_ok   = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff_ext[WIDTH-1] != a_op[WIDTH-1]);
        cv_ok   = 1'b1;
      end
      OP_AND:  alu_res = a_op & b_op;
      OP_ORR:  alu_res = a_op | b_op;
      OP_EOR:  alu_res = a_op ^ b_op;
      OP_MOV:  alu_res = b_op;
      OP_MUL:  alu_res = acc_q;
      default: nz_ok   = 1'b0;
    endcase
  end

  assign mul_start = e_q.valid && cp && (e_q.alu_ctrl == OP_MUL);
  assign busy      = ((state_q == MUL_IDLE) && mul_start) || (state_q == MUL_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      MUL_IDLE: begin
        if (mul_start && !bus.flush) begin
          mcand_d  = a_op;
          mplier_d = b_op;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (bus.flush) begin
          state_d = MUL_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_d = MUL_DONE;
        end
      end
      // A stalled DONE keeps its product until the instruction can leave E.
      MUL_DONE: if (bus.flush || !bus.stall) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Stall freezes E and sends bubbles to M so nothing retires twice.
  assign move = !busy && !bus.stall;
  assign gate = e_q.valid && cp;

  always_comb begin
    e_d     = e_q;
    m_d     = '0;
    flags_d = flags_q;
    if (bus.flush) begin
      e_d.valid = 1'b0;
    end else if (!bus.stall && !busy) begin
      e_d.valid      = bus.valid_d;
      e_d.alu_ctrl   = bus.alu_ctrl_d;
      e_d.cond       = bus.cond_d;
      e_d.reg_write  = bus.reg_write_d;
      e_d.mem_write  = bus.mem_write_d;
      e_d.mem_to_reg = bus.mem_to_reg_d;
      e_d.pc_src     = bus.pc_src_d;
      e_d.alu_src    = bus.alu_src_d;
      e_d.flag_write = bus.flag_write_d;
      e_d.rd1        = bus.rd1_d;
      e_d.rd2        = bus.rd2_d;
      e_d.ext        = bus.ext_d;
      e_d.wa         = bus.wa_d;
    end
    if (move) begin
      m_d.valid      = e_q.valid;
      m_d.reg_write  = e_q.reg_write && gate;
      m_d.mem_write  = e_q.mem_write && gate;
      m_d.mem_to_reg = e_q.mem_to_reg && e_q.valid;
      m_d.pc_src     = e_q.pc_src && gate;
      m_d.alu_result = alu_res;
      m_d.write_data = b_reg;
      m_d.wa         = e_q.wa;
      if (gate) begin
        if (e_q.flag_write[1] && nz_ok) flags_d[3:2] = {alu_res[WIDTH-1], alu_res == '0};
        if (e_q.flag_write[0] && cv_ok) flags_d[1:0] = {alu_c, alu_v};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      flags_q  <= '0;
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      flags_q  <= flags_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.busy         = busy;
  assign bus.valid_m      = m_q.valid;
  assign bus.reg_write_m  = m_q.reg_write;
  assign bus.mem_write_m  = m_q.mem_write;
  assign bus.mem_to_reg_m = m_q.mem_to_reg;
  assign bus.pc_src_m     = m_q.pc_src;
  assign bus.alu_result_m = m_q.alu_result;
  assign bus.write_data_m = m_q.write_data;
  assign bus.wa_m         = m_q.wa;
  assign bus.flags        = flags_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// Bench for exec_stage_mc: transaction-level model checked every cycle on the
// 32-bit instance, plus literal expectations on 32-bit and 8-bit instances.
module tb_exec_stage_mc;
  localparam int W  = 32;
  localparam int W8 = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_stage_if #(.WIDTH(W),  .AW(AW)) bus ();
  exec_stage_if #(.WIDTH(W8), .AW(AW)) bus8 ();

  exec_stage_mc #(.WIDTH(W),  .AW(AW)) dut  (.clk(clk), .reset(rst_n), .bus(bus));
  exec_stage_mc #(.WIDTH(W8), .AW(AW)) dut8 (.clk(clk), .reset(rst_n), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 32-bit instance ----------------
  typedef struct packed {
    logic        valid;
    logic [3:0]  op, cond;
    logic        rw, mw, m2r, pcs, alu_src;
    logic [1:0]  fw;
    logic [31:0] rd1, rd2, ext;
    logic [3:0]  wa;
  } ins_t;

  typedef struct packed {
    logic [31:0] res;
    logic        n, z, c, v, nz_ok, cv_ok;
  } alu_t;

  ins_t        me = '0;
  int          mage = 0;          // cycles the E instruction has spent busy
  logic [31:0] mprod = '0;
  logic [3:0]  mflags = '0;
  logic        exp_valid = 0, exp_rw = 0, exp_mw = 0, exp_m2r = 0, exp_pcs = 0, exp_cp = 0;
  logic [31:0] exp_res = '0, exp_wd = '0;
  logic [3:0]  exp_wa = '0;
  logic        m_cp, m_busy, m_g;
  logic [31:0] m_a, m_breg, m_b;
  alu_t        m_r;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'b01) return bus.result_w;
    if (sel == 2'b10) return bus.alu_fwd_m;
    return r;
  endfunction

  function automatic alu_t model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] prod);
    alu_t   r;
    longint sa, sb, s;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.nz_ok = 1'b1;
    case (op)
      4'd0: begin
        r.res = a + b;
        r.c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        s     = sa + sb;
        r.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.cv_ok = 1'b1;
      end
      4'd1: begin
        r.res = a - b;
        r.c   = a >= b;
        s     = sa - sb;
        r.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.cv_ok = 1'b1;
      end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: r.res = b;
      4'd6: r.res = prod;
      default: r.nz_ok = 1'b0;
    endcase
    r.n = r.res[31];
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  function automatic logic model_busy();
    return me.valid && (me.op == 4'd6) && cond_ok(me.cond, mflags) && (mage <= W);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me = '0; mage = 0; mprod = '0; mflags = '0;
      exp_valid = 0; exp_rw = 0; exp_mw = 0; exp_m2r = 0; exp_pcs = 0; exp_cp = 0;
      exp_res = '0; exp_wd = '0; exp_wa = '0;
    end else begin
      m_cp   = cond_ok(me.cond, mflags);
      m_busy = model_busy();
      m_a    = pick(bus.fwd_a, me.rd1);
      m_breg = pick(bus.fwd_b, me.rd2);
      m_b    = me.alu_src ? me.ext : m_breg;
      m_r    = model_alu(me.op, m_a, m_b, mprod);
      exp_valid = 0; exp_rw = 0; exp_mw = 0; exp_m2r = 0; exp_pcs = 0; exp_cp = 0;
      if (m_busy) begin
        if (mage == 0) mprod = m_a * m_b;
        mage++;
        if (bus.flush) begin me.valid = 1'b0; mage = 0; end
      end else begin
        if (!bus.stall) begin
          m_g       = me.valid && m_cp;
          exp_valid = me.valid;
          exp_rw    = me.rw && m_g;
          exp_mw    = me.mw && m_g;
          exp_pcs   = me.pcs && m_g;
          exp_m2r   = me.m2r && me.valid;
          exp_cp    = m_cp;
          exp_res   = m_r.res;
          exp_wd    = m_breg;
          exp_wa    = me.wa;
          if (m_g && me.fw[1] && m_r.nz_ok) mflags[3:2] = {m_r.n, m_r.z};
          if (m_g && me.fw[0] && m_r.cv_ok) mflags[1:0] = {m_r.c, m_r.v};
        end
        if (bus.flush) begin
          me.valid = 1'b0; mage = 0;
        end else if (!bus.stall) begin
          me = '{bus.valid_d, bus.alu_ctrl_d, bus.cond_d, bus.reg_write_d, bus.mem_write_d,
                 bus.mem_to_reg_d, bus.pc_src_d, bus.alu_src_d, bus.flag_write_d,
                 bus.rd1_d, bus.rd2_d, bus.ext_d, bus.wa_d};
          mage = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, model_busy());
    check("m_ctrl", {bus.valid_m, bus.reg_write_m, bus.mem_write_m, bus.pc_src_m},
          {exp_valid, exp_rw, exp_mw, exp_pcs});
    check("flags", bus.flags, mflags);
    if (exp_valid && exp_cp)
      check("m_data", {bus.alu_result_m, bus.write_data_m, bus.wa_m, bus.mem_to_reg_m},
            {exp_res, exp_wd, exp_wa, exp_m2r});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] cond, input logic [1:0] fw,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] ext,
                       input logic alu_src, input logic rw, input logic mw, input logic pcs,
                       input logic [3:0] wa);
    bus.valid_d = 1'b1; bus.alu_ctrl_d = op; bus.cond_d = cond; bus.flag_write_d = fw;
    bus.rd1_d = rd1; bus.rd2_d = rd2; bus.ext_d = ext; bus.alu_src_d = alu_src;
    bus.reg_write_d = rw; bus.mem_write_d = mw; bus.pc_src_d = pcs;
    bus.mem_to_reg_d = 1'b0; bus.wa_d = wa;
  endtask

  task automatic drive8(input logic [3:0] op, input logic [3:0] cond, input logic [1:0] fw,
                        input logic [7:0] rd1, input logic [7:0] rd2);
    bus8.valid_d = 1'b1; bus8.alu_ctrl_d = op; bus8.cond_d = cond; bus8.flag_write_d = fw;
    bus8.rd1_d = rd1; bus8.rd2_d = rd2; bus8.ext_d = '0; bus8.alu_src_d = 1'b0;
    bus8.reg_write_d = 1'b1; bus8.mem_write_d = 1'b0; bus8.pc_src_d = 1'b0;
    bus8.mem_to_reg_d = 1'b0; bus8.wa_d = 4'd2;
  endtask

  task automatic init_buses();
    bus.stall = 0; bus.flush = 0; bus.valid_d = 0; bus.alu_ctrl_d = 0; bus.cond_d = 0;
    bus.reg_write_d = 0; bus.mem_write_d = 0; bus.mem_to_reg_d = 0; bus.pc_src_d = 0;
    bus.alu_src_d = 0; bus.flag_write_d = 0; bus.rd1_d = 0; bus.rd2_d = 0; bus.ext_d = 0;
    bus.wa_d = 0; bus.fwd_a = 0; bus.fwd_b = 0; bus.alu_fwd_m = 0; bus.result_w = 0;
    bus8.stall = 0; bus8.flush = 0; bus8.valid_d = 0; bus8.alu_ctrl_d = 0; bus8.cond_d = 0;
    bus8.reg_write_d = 0; bus8.mem_write_d = 0; bus8.mem_to_reg_d = 0; bus8.pc_src_d = 0;
    bus8.alu_src_d = 0; bus8.flag_write_d = 0; bus8.rd1_d = 0; bus8.rd2_d = 0; bus8.ext_d = 0;
    bus8.wa_d = 0; bus8.fwd_a = 0; bus8.fwd_b = 0; bus8.alu_fwd_m = 0; bus8.result_w = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, nbub, nvalid;
    init_buses();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("reset_out", {bus.busy, bus.valid_m, bus.flags, bus.alu_result_m}, '0);
    step();

    // Flag-setting compare, then taken and not-taken conditional branches.
    drive(4'd1, 4'hE, 2'b11, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    step();
    drive(4'd0, 4'h0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    bus.valid_d = 0;
    check("sub_flags", bus.flags, 4'b0110);
    step();
    check("beq_taken", {bus.valid_m, bus.pc_src_m}, 2'b11);
    drive(4'd0, 4'h1, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step(); bus.valid_d = 0; step();
    check("bne_not_taken", {bus.valid_m, bus.pc_src_m, bus.mem_write_m}, 3'b100);

    // Forwarding onto operand A and B.
    bus.alu_fwd_m = 32'd7; bus.result_w = 32'd9;
    for (int i = 0; i < 3; i++) begin
      logic [1:0]  sel_tab [3];
      logic [31:0] exp_tab [3];
      sel_tab = '{2'b10, 2'b01, 2'b11};
      exp_tab = '{32'd8, 32'd10, 32'd2};
      drive(4'd0, 4'hE, 2'b00, 32'd1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      step();
      bus.fwd_a = sel_tab[i]; bus.valid_d = 0;
      step();
      check($sformatf("fwd_a_%0d", i), bus.alu_result_m, exp_tab[i]);
    end
    bus.fwd_a = 2'b00;
    drive(4'd0, 4'hE, 2'b00, 32'd1, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    step(); bus.fwd_b = 2'b10; bus.valid_d = 0; step();
    check("fwd_b", {bus.alu_result_m, bus.write_data_m}, {32'd8, 32'd7});
    bus.fwd_b = 2'b00;

    // 32-bit multiply with forwarding and stall noise during RUN.
    drive(4'd6, 4'hE, 2'b10, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    step();
    bus.valid_d = 0;
    nbusy = 0; nbub = 0;
    for (int i = 0; i < 200 && bus.busy; i++) begin
      nbusy++;
      if (nbusy > 1) begin
        bus.fwd_a = 2'($urandom_range(0, 3)); bus.fwd_b = 2'($urandom_range(0, 3));
        bus.alu_fwd_m = $urandom; bus.result_w = $urandom;
        bus.stall = (nbusy < 20) && (nbusy % 3 == 0);
      end
      step();
      if (!bus.valid_m) nbub++;
    end
    bus.fwd_a = 0; bus.fwd_b = 0; bus.stall = 0;
    check("mul32_busy_cycles", nbusy, 33);
    check("mul32_bubbles", nbub, 33);
    step();
    check("mul32_result", {bus.valid_m, bus.reg_write_m, bus.alu_result_m}, {2'b11, 32'h0005_000F});
    check("mul32_flags", bus.flags, 4'b0010);

    // Reset in the middle of RUN.
    drive(4'd6, 4'hE, 2'b00, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    step(); bus.valid_d = 0; step(); step(); step();
    check("pre_reset_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.busy, bus.valid_m, bus.flags}, 6'b0);
    #1 rst_n = 1'b1;
    step();
    drive(4'd0, 4'hE, 2'b00, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    step(); bus.valid_d = 0; step();
    check("add_after_reset", {bus.valid_m, bus.alu_result_m}, {1'b1, 32'd5});

    // Flush at RUN cnt=3 aborts the multiply.
    drive(4'd6, 4'hE, 2'b00, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    step(); bus.valid_d = 0;
    step(); step(); step(); step();
    check("busy_before_flush", bus.busy, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy_drop", {bus.busy, bus.valid_m}, 2'b00);
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.valid_m) nvalid++;
    end
    check("flush_no_result", nvalid, 0);
    drive(4'd0, 4'hE, 2'b00, 32'h10, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    step(); bus.valid_d = 0; step();
    check("add_after_flush", {bus.valid_m, bus.alu_result_m, bus.wa_m}, {1'b1, 32'h30, 4'd8});

    // 8-bit instance: set C/V, multiply, then a never-condition multiply.
    drive8(4'd0, 4'hE, 2'b11, 8'h80, 8'h80);
    step(); bus8.valid_d = 0; step();
    check("w8_add", {bus8.alu_result_m, bus8.flags}, {8'h00, 4'b0111});
    drive8(4'd6, 4'hE, 2'b10, 8'hFF, 8'hFF);
    step(); bus8.valid_d = 0;
    nbusy = 0;
    for (int i = 0; i < 50 && bus8.busy; i++) begin
      nbusy++;
      step();
    end
    check("w8_busy_cycles", nbusy, 9);
    step();
    check("w8_mul", {bus8.valid_m, bus8.alu_result_m, bus8.flags}, {1'b1, 8'h01, 4'b0011});
    drive8(4'd6, 4'hF, 2'b11, 8'd3, 8'd4);
    step(); bus8.valid_d = 0;
    check("w8_nv_busy", bus8.busy, 1'b0);
    step();
    check("w8_nv_m", {bus8.busy, bus8.valid_m, bus8.reg_write_m, bus8.flags}, {3'b010, 4'b0011});
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute stage for the pipelined ARM core. It holds the D→E pipeline register, forwarding operand muxes, conditional-execution logic with a local NZCV register, a single-cycle ALU and an iterative multi-cycle multiplier. While a multiply runs it raises `busy` so the hazard unit stalls fetch and decode. It feeds the E→M register for the memory stage.

Parameters:
WIDTH, 32, datapath width (≥8)
AW, 4, register-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold the E register (from hazard unit)
flush  in  1  synchronous: load a bubble into E
valid_d  in  1  decode slot holds an instruction
alu_ctrl_d  in  4  operation code
cond_d  in  4  ARM condition field
reg_write_d, mem_write_d, mem_to_reg_d, pc_src_d, alu_src_d  in  1 each  decode controls
flag_write_d  in  2  [1]=update NZ, [0]=update CV
rd1_d, rd2_d, ext_d  in  WIDTH  register operands and extended immediate
wa_d  in  AW  destination register
fwd_a, fwd_b  in  2  forward select: 00=reg, 01=result_w, 10=alu_fwd_m, 11=reg
alu_fwd_m  in  WIDTH  value forwarded from M
result_w  in  WIDTH  value forwarded from W
busy  out  1  multiply in progress; upstream must stall
valid_m, reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m  out  1 each  M controls
alu_result_m, write_data_m  out  WIDTH  M data
wa_m  out  AW  M destination register
flags  out  4  NZCV

Behaviour:
- Reset (reset=0, asynchronous): E and M registers cleared and all valids 0, flags=0000, multiplier FSM=IDLE, busy=0. Every output is 0.
- E register:
  - loads D inputs on a clock edge when !stall && !busy.
  - flush has priority over load: valid_e=0.
  - flush while busy aborts the multiply: FSM→IDLE, valid_e=0, and M receives a bubble.
- Operands:
  - A = mux(fwd_a).
  - B_reg = mux(fwd_b).
  - B = alu_src_e ? ext_e : B_reg.
  - write_data_m ← B_reg.
- Condition pass (cp) is evaluated against the current flags. Codes 0000..1110 = EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 1111 never passes.
- ALU codes:
  - 0000 ADD, 0001 SUB (A−B, C = no-borrow), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (B), 0110 MUL.
  - Other codes give result 0 and no flag update.
  - Result is WIDTH bits. ADD and SUB produce C and V; logic ops and MUL produce NZ only.
- Flags update on the edge where the instruction moves to M, only if valid && cp. NZ updates when flag_write[1]; CV updates when flag_write[0] and the op is ADD/SUB.
- M controls: reg_write_m, mem_write_m and pc_src_m are the E values ANDed with valid_e && cp. valid_m = valid_e. Non-MUL latency: 1 edge E→M.
- MUL FSM (only for valid_e && cp && MUL):
  - IDLE: busy=1; capture A and B into multiplicand/multiplier regs, acc=0, cnt=0; →RUN.
  - RUN: busy=1; shift-add one multiplier bit per cycle, cnt++; when cnt==WIDTH−1, →DONE.
  - DONE: busy=0; acc[WIDTH−1:0] goes to M on this edge; →IDLE.
  - Operands are latched in IDLE, so forwarding-source changes during RUN are ignored.
  - While busy, M receives bubbles (valid_m=0, all write enables 0).
  - A MUL occupies E for WIDTH+2 cycles, with busy high for WIDTH+1 of them.
- A MUL with a failed condition takes 1 cycle with no busy and reaches M with its writes disabled.
- stall asserted during RUN has no effect on the FSM.

Test Plan:
1. Reset mid-RUN → busy=0, valid_m=0, flags=0000 immediately; the next ADD 2+3 gives alu_result_m=5.
2. SUB 5−5 with flag_write=11, then BEQ-style pc_src with cond 0000 → flags=0110 (Z=1, C=1); pc_src_m=1 the cycle after. Same with cond 0001 → pc_src_m=0, valid_m=1.
3. Forwarding: rd1=1, alu_fwd_m=7, result_w=9, ADD with B=1: fwd_a=10 → 8; fwd_a=01 → 10; fwd_a=11 → 2.
4. WIDTH=32, MUL 0x0001_0003 × 0x0000_0005 → busy high 33 cycles, then alu_result_m=0x0005_000F. Exactly 33 bubbles precede it in M. Forwarding inputs toggled during RUN do not alter the result.
5. WIDTH=8, MUL 0xFF×0xFF → alu_result_m=0x01 with N=0, Z=0, C/V unchanged. A MUL with cond 1111 → busy never asserts and reg_write_m=0.
6. MUL then flush asserted at RUN cnt=3 → busy falls next cycle, no MUL result reaches M, and a following ADD completes normally.
